uart_byte_rx: RTL and testbench

UART_BYTE_RX -- requirements
Module: uart_byte_rx

---
 rtl/uart_byte_rx.sv | 251 +++++++++++++++++++++++++
 tb/tb_uart_byte_rx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_rx.sv
// uart_byte_rx -- oversampled UART byte receiver with a first-word-fall-through FIFO.
//
// Build option: define UART_RX_PARITY_EN to expect one even-parity bit after the
// data bits (8E1); without it the frame is 8N1 and parity_err is tied low.
//
// Parameters
//   DELAY_FRAMES : clk cycles per bit (4..8191), default 234 (27 MHz / 115200)
//   FIFO_DEPTH   : receive FIFO depth, power of two 2..64, default 8
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   uart_rx    : serial input, idles high, asynchronous to clk
//   rx_data    : byte at the FIFO head (0 while empty)
//   rx_valid   : FIFO non-empty
//   rx_ready   : consumer accepts the head byte (pop when rx_valid & rx_ready)
//   frame_err  : one-cycle pulse, stop bit sampled low
//   parity_err : one-cycle pulse, parity mismatch with a good stop bit
//   overflow   : one-cycle pulse, good byte dropped because the FIFO was full
//   fifo_count : bytes currently held in the FIFO
module uart_byte_rx #(
    parameter int DELAY_FRAMES = 234,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          uart_rx,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [12:0]   BIT_FULL = 13'(DELAY_FRAMES);
    localparam logic [12:0]   BIT_HALF = 13'(DELAY_FRAMES / 2);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY    = 3'd3;
`endif
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_HIGH = 3'd5;

    // Two-flop synchronizer, reset to the idle (high) line level
    logic sync1_q, sync2_q;
    logic rxs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
        end
    end

    assign rxs = sync2_q;

    // Receive FSM
    logic [2:0]  state_q, state_d;
    logic [12:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        push;
    logic        fe_d;
    logic        frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic        par_q, par_d;
    logic        pe_d;
    logic        parity_err_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        push    = 1'b0;
        fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        pe_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rxs) begin
                    state_d = S_START;
                    cnt_d   = 13'd1;
                end
            end
            S_START: begin
                if (cnt_q == BIT_HALF) begin
                    if (rxs) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = 13'd1;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_FULL) begin
                    shift_d = {rxs, shift_q[7:1]};
                    cnt_d   = 13'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == BIT_FULL) begin
                    par_d   = rxs;
                    cnt_d   = 13'd1;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == BIT_FULL) begin
                    cnt_d = '0;
                    if (rxs) begin
                        state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        // Even parity: data ones plus parity bit must be even
                        if (par_q != ^shift_q) begin
                            pe_d = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
`else
                        push = 1'b1;
`endif
                    end else begin
                        fe_d    = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
            S_WAIT_HIGH: begin
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FIFO control; a full FIFO still accepts a push when the head is popped
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          pop, full, wr_en, ovf_d, overflow_q;

    assign pop   = rx_valid && rx_ready;
    assign full  = (count_q == DEPTH_C);
    assign wr_en = push && (!full || pop);
    assign ovf_d = push && full && !pop;

    always_comb begin
        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !wr_en) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_err_q <= fe_d;
            overflow_q  <= ovf_d;
            count_q     <= count_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= pe_d;
`endif
        end
    end

    // Storage needs no reset: it is only observable through rx_data while non-empty
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign rx_valid   = (count_q != '0);
    assign rx_data    = rx_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_count = count_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx -- self-checking bench for uart_byte_rx.
// Frames are driven bit-serially; a queue-based model decides per frame whether the
// byte should appear, be dropped as overflow, or raise frame/parity errors.
// Honours UART_RX_PARITY_EN when defined for the build.
module tb_uart_byte_rx;

    localparam int DF    = 16;
    localparam int DEPTH = 8;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif
    // Posedges from the line's falling edge to the edge that registers the stop sample:
    // 2 synchronizer flops + IDLE detect, half a bit to mid-start, then NBITS bit times.
    localparam int STOP_EDGE = 3 + DF / 2 + NBITS * DF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overflow;
    logic [3:0] fifo_count;

    always #5 clk = ~clk;

    uart_byte_rx #(
        .DELAY_FRAMES (DF),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx    (uart_rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [7:0] exp_q[$];
    int         fe_cnt = 0, pe_cnt = 0, of_cnt = 0, valid_cycles = 0;
    int         exp_fe = 0, exp_pe = 0, exp_of = 0;
    logic       rnd_ready = 1'b0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs change just after the rising edge so the falling-edge monitor sees
    // exactly what the next rising edge will use.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference outcome of one frame
    task automatic model_frame(input logic [7:0] b, input int stop_low, input int par_flip);
        if (stop_low > 0)               exp_fe++;
        else if (par_flip != 0)         exp_pe++;
        else if (exp_q.size() >= DEPTH) exp_of++;
        else                            exp_q.push_back(b);
    endtask

    task automatic send_frame(input logic [7:0] b, input int stop_low, input int par_flip);
        uart_rx = 1'b0;
        tick(DF);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(DF);
        end
`ifdef UART_RX_PARITY_EN
        uart_rx = (^b) ^ (par_flip != 0);
        tick(DF);
`endif
        model_frame(b, stop_low, par_flip);
        if (stop_low > 0) begin
            uart_rx = 1'b0;
            tick(stop_low * DF);
            uart_rx = 1'b1;
            tick(DF);
        end else begin
            uart_rx = 1'b1;
            tick(DF);
        end
    endtask

    task automatic check_counts(input string tag);
        check_eq({tag, "_fe"}, 32'(fe_cnt), 32'(exp_fe));
        check_eq({tag, "_pe"}, 32'(pe_cnt), 32'(exp_pe));
        check_eq({tag, "_of"}, 32'(of_cnt), 32'(exp_of));
    endtask

    // Output monitor: pulse counting, FIFO order and head stability
    always @(negedge clk) begin
        if (frame_err)  fe_cnt++;
        if (parity_err) pe_cnt++;
        if (overflow)   of_cnt++;
        if (rx_valid)   valid_cycles++;
        if (prev_hold && rx_valid)
            check_eq("hold_data", 32'(rx_data), 32'(prev_data));
        if (rx_valid && rx_ready) begin
            check_eq("pop_avail", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                check_eq("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
        prev_hold = rx_valid && !rx_ready;
        prev_data = rx_data;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) rx_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int vc0;
        logic [7:0] b;
        int sl, pf;

        // Reset values
        tick(3);
        check_eq("rst_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_data", 32'(rx_data), 32'd0);
        check_eq("rst_count", 32'(fifo_count), 32'd0);
        check_eq("rst_fe", 32'(frame_err), 32'd0);
        check_eq("rst_pe", 32'(parity_err), 32'd0);
        check_eq("rst_of", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        tick(5);

        // Single 0x4C, exact push-to-visible timing with immediate pop
        rx_ready = 1'b1;
        vc0 = valid_cycles;
        fork
            send_frame(8'h4C, 0, 0);
            begin
                repeat (STOP_EDGE - 1) @(posedge clk);
                @(negedge clk);
                check_eq("t_before", 32'(rx_valid), 32'd0);
                @(negedge clk);
                check_eq("t_valid", 32'(rx_valid), 32'd1);
                check_eq("t_data", 32'(rx_data), 32'h4C);
                @(negedge clk);
                check_eq("t_after", 32'(rx_valid), 32'd0);
            end
        join
        check_eq("t_vcycles", 32'(valid_cycles - vc0), 32'd1);
        check_counts("t");

        // Short low glitch on an idle line
        vc0 = valid_cycles;
        uart_rx = 1'b0;
        tick(DF / 4);
        uart_rx = 1'b1;
        tick(3 * DF);
        check_eq("g_vcycles", 32'(valid_cycles - vc0), 32'd0);
        check_counts("g");

        // Break after 0x55, then 0xAA
        send_frame(8'h55, 3, 0);
        check_eq("brk_fe_once", 32'(fe_cnt), 32'(exp_fe));
        check_eq("brk_count", 32'(fifo_count), 32'd0);
        send_frame(8'hAA, 0, 0);
        tick(4);
        check_eq("brk_drained", 32'(exp_q.size()), 32'd0);
        check_counts("brk");

        // Fill past depth with consumer stalled
        rx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0);
        check_eq("ovf_count", 32'(fifo_count), 32'(DEPTH));
        check_eq("ovf_head", 32'(rx_data), 32'h01);
        check_counts("ovf");
        rx_ready = 1'b1;
        tick(2 * DEPTH);
        check_eq("ovf_drain_cnt", 32'(fifo_count), 32'd0);
        check_eq("ovf_drain_q", 32'(exp_q.size()), 32'd0);

`ifdef UART_RX_PARITY_EN
        // Bad then good parity on 0x03
        vc0 = valid_cycles;
        send_frame(8'h03, 0, 1);
        check_eq("par_bad_v", 32'(valid_cycles - vc0), 32'd0);
        check_counts("par_bad");
        send_frame(8'h03, 0, 0);
        tick(4);
        check_eq("par_good_v", 32'(valid_cycles - vc0), 32'd1);
        check_counts("par_good");
`endif

        // Reset in the middle of bit 4, with a byte already queued
        rx_ready = 1'b0;
        send_frame(8'h5A, 0, 0);
        check_eq("mr_pre_count", 32'(fifo_count), 32'd1);
        uart_rx = 1'b0;
        tick(DF);
        for (int i = 0; i < 4; i++) begin
            uart_rx = 1'b0;
            tick(DF);
        end
        uart_rx = 1'b1;
        tick(DF / 2);
        rst_n = 1'b0;
        exp_q.delete();
        tick(2);
        check_eq("mr_valid", 32'(rx_valid), 32'd0);
        check_eq("mr_data", 32'(rx_data), 32'd0);
        check_eq("mr_count", 32'(fifo_count), 32'd0);
        check_eq("mr_errs", 32'({frame_err, parity_err, overflow}), 32'd0);
        rst_n = 1'b1;
        tick(3 * DF);
        check_eq("mr_idle_count", 32'(fifo_count), 32'd0);
        rx_ready = 1'b1;
        vc0 = valid_cycles;
        send_frame(8'h68, 0, 0);
        tick(4);
        check_eq("mr_rx_v", 32'(valid_cycles - vc0), 32'd1);
        check_eq("mr_rx_q", 32'(exp_q.size()), 32'd0);
        check_counts("mr");

        // Random traffic with random back-pressure and occasional bad frames
        rnd_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            b  = 8'($urandom);
            sl = ($urandom_range(0, 7) == 0) ? 1 : 0;
            pf = 0;
`ifdef UART_RX_PARITY_EN
            pf = ($urandom_range(0, 5) == 0) ? 1 : 0;
`endif
            send_frame(b, sl, pf);
            check_counts("rnd");
            tick($urandom_range(0, DF));
        end
        rnd_ready = 1'b0;
        tick(1);
        rx_ready = 1'b1;
        tick(2 * DEPTH);
        check_eq("rnd_drain_cnt", 32'(fifo_count), 32'd0);
        check_eq("rnd_drain_q", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
